// File: rtl/string_line_buffer.sv
// string_line_buffer
// Consumes make-code events from the PS/2 keyboard receiver, translates set-2
// scan codes (with shift) to ASCII, and assembles them into a line buffer with
// backspace editing. Enter commits the line and locks editing until the
// display/compare logic acknowledges it. The buffer is read through a
// registered read port.
module string_line_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scan_code,
    input  logic [18:0]   count_num,
    input  logic          shift,
    input  logic          line_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   length,
    output logic          line_done,
    output logic          char_valid,
    output logic [7:0]    last_ascii,
    output logic          full
);

    localparam logic [7:0]  KEY_BKSP  = 8'h66;
    localparam logic [7:0]  KEY_ENTER = 8'h5A;
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L     = {{AW{1'b0}}, 1'b1};

    logic [18:0]   prev_cnt_q;
    logic          key_evt;
    logic [7:0]    ascii_c;
    logic          mapped_c;

    logic [AW:0]   length_q,     length_d;
    logic          line_done_q,  line_done_d;
    logic          char_valid_q, char_valid_d;
    logic [7:0]    last_ascii_q, last_ascii_d;
    logic          full_q,       full_d;
    logic          wr_en;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem_q [DEPTH];

    // Track the receiver counter every cycle (reset included) so the first
    // cycle after reset never sees a stale difference.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        prev_cnt_q <= count_num;
    end

    assign key_evt = (count_num != prev_cnt_q);

    // Set-2 scan code plus shift to ASCII; unmapped codes give 0x00.
    always_comb begin
        // NOTE: default assignment first so no path leaves ascii_c unassigned (no latch).
        ascii_c = 8'h00;
        case (scan_code)
            8'h1C: ascii_c = 8'h61; // a
            8'h32: ascii_c = 8'h62; // b
            8'h21: ascii_c = 8'h63; // c
            8'h23: ascii_c = 8'h64; // d
            8'h24: ascii_c = 8'h65; // e
            8'h2B: ascii_c = 8'h66; // f
            8'h34: ascii_c = 8'h67; // g
            8'h33: ascii_c = 8'h68; // h
            8'h43: ascii_c = 8'h69; // i
            8'h3B: ascii_c = 8'h6A; // j
            8'h42: ascii_c = 8'h6B; // k
            8'h4B: ascii_c = 8'h6C; // l
            8'h3A: ascii_c = 8'h6D; // m
            8'h31: ascii_c = 8'h6E; // n
            8'h44: ascii_c = 8'h6F; // o
            8'h4D: ascii_c = 8'h70; // p
            8'h15: ascii_c = 8'h71; // q
            8'h2D: ascii_c = 8'h72; // r
            8'h1B: ascii_c = 8'h73; // s
            8'h2C: ascii_c = 8'h74; // t
            8'h3C: ascii_c = 8'h75; // u
            8'h2A: ascii_c = 8'h76; // v
            8'h1D: ascii_c = 8'h77; // w
            8'h22: ascii_c = 8'h78; // x
            8'h35: ascii_c = 8'h79; // y
            8'h1A: ascii_c = 8'h7A; // z
            8'h16: ascii_c = shift ? 8'h21 : 8'h31; // ! 1
            8'h1E: ascii_c = shift ? 8'h40 : 8'h32; // @ 2
            8'h26: ascii_c = shift ? 8'h23 : 8'h33; // # 3
            8'h25: ascii_c = shift ? 8'h24 : 8'h34; // $ 4
            8'h2E: ascii_c = shift ? 8'h25 : 8'h35; // % 5
            8'h36: ascii_c = shift ? 8'h5E : 8'h36; // ^ 6
            8'h3D: ascii_c = shift ? 8'h26 : 8'h37; // & 7
            8'h3E: ascii_c = shift ? 8'h2A : 8'h38; // * 8
            8'h46: ascii_c = shift ? 8'h28 : 8'h39; // ( 9
            8'h45: ascii_c = shift ? 8'h29 : 8'h30; // ) 0
            8'h29: ascii_c = 8'h20;                 // space, shift-independent
            default: ascii_c = 8'h00;
        endcase
        // Letters are decoded lowercase above; shift folds them to uppercase.
        if (shift && (ascii_c >= 8'h61) && (ascii_c <= 8'h7A)) begin
            ascii_c = ascii_c - 8'h20;
        end
    end

    assign mapped_c = (ascii_c != 8'h00);

    // Next-state for the editing controller: ack unlocks a committed line,
    // otherwise one key event is applied per cycle while unlocked.
    always_comb begin
        length_d     = length_q;
        line_done_d  = line_done_q;
        char_valid_d = 1'b0;
        last_ascii_d = last_ascii_q;
        wr_en        = 1'b0;
        if (line_done_q) begin
            // Keys arriving while locked are dropped, even alongside an ack.
            if (line_ack) begin
                line_done_d = 1'b0;
                length_d    = '0;
            end
        end else if (key_evt) begin
            if (scan_code == KEY_BKSP) begin
                if (length_q != '0) begin
                    length_d = length_q - ONE_L;
                end
            end else if (scan_code == KEY_ENTER) begin
                line_done_d = 1'b1;
            end else if (mapped_c && !full_q) begin
                wr_en        = 1'b1;
                length_d     = length_q + ONE_L;
                char_valid_d = 1'b1;
                last_ascii_d = ascii_c;
            end
        end
        full_d = (length_d == DEPTH_L);
    end

    // Controller registers; full is registered alongside length so both move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            length_q     <= '0;
            line_done_q  <= 1'b0;
            char_valid_q <= 1'b0;
            last_ascii_q <= 8'h00;
            full_q       <= 1'b0;
        end else begin
            length_q     <= length_d;
            line_done_q  <= line_done_d;
            char_valid_q <= char_valid_d;
            last_ascii_q <= last_ascii_d;
            full_q       <= full_d;
        end
    end

    // Append write port; the write address is the current length (never DEPTH when writing).
    // NOTE: the character array has no reset; only control state is reset, stale data is harmless.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[length_q[AW-1:0]] <= ascii_c;
        end
    end

    // Registered read port; a same-cycle write to rd_addr returns the old byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign length     = length_q;
    assign line_done  = line_done_q;
    assign char_valid = char_valid_q;
    assign last_ascii = last_ascii_q;
    assign full       = full_q;

endmodule

// File: tb/tb_string_line_buffer.sv
// Testbench for string_line_buffer: directed scenarios followed by randomized
// key traffic, all checked cycle by cycle against a line-level model.
module tb_string_line_buffer;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    scan_code;
    logic [18:0]   count_num;
    logic          shift;
    logic          line_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   length;
    logic          line_done;
    logic          char_valid;
    logic [7:0]    last_ascii;
    logic          full;

    string_line_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .count_num  (count_num),
        .shift      (shift),
        .line_ack   (line_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .length     (length),
        .line_done  (line_done),
        .char_valid (char_valid),
        .last_ascii (last_ascii),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Key tables in character order.
    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    string lower_str   = "abcdefghijklmnopqrstuvwxyz";
    string digit_str   = "1234567890";
    string shifted_str = "!@#$%^&*()";

    // Reference model state.
    int          m_len;
    bit          m_done;
    logic [7:0]  m_last;
    logic [7:0]  mem_m [DEPTH];
    bit          mem_known [DEPTH];
    logic [18:0] cnt;
    int          cv_seen;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit xlate(input logic [7:0] code, input bit sh, output logic [7:0] a);
        a = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (LETTER_CODES[i] == code) begin
                a = 8'(lower_str[i]);
                if (sh) a = a - 8'd32;
                return 1'b1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (DIGIT_CODES[i] == code) begin
                a = sh ? 8'(shifted_str[i]) : 8'(digit_str[i]);
                return 1'b1;
            end
        end
        if (code == 8'h29) begin
            a = 8'h20;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit rst, input bit evt, input logic [7:0] code,
                       input bit sh, input bit ack, input int addr);
        logic [7:0] a;
        logic [7:0] exp_rd;
        bit         rd_known;
        bit         exp_cv;
        reset     = rst;
        scan_code = code;
        shift     = sh;
        line_ack  = ack;
        rd_addr   = addr[AW-1:0];
        if (evt) cnt = cnt + 19'd1 + 19'($urandom_range(0, 2));
        count_num = cnt;

        rd_known = mem_known[addr] || rst;
        exp_rd   = rst ? 8'h00 : mem_m[addr];
        exp_cv   = 1'b0;
        if (rst) begin
            m_len  = 0;
            m_done = 1'b0;
            m_last = 8'h00;
        end else if (m_done) begin
            if (ack) begin
                m_done = 1'b0;
                m_len  = 0;
            end
        end else if (evt) begin
            if (code == 8'h66) begin
                if (m_len > 0) m_len--;
            end else if (code == 8'h5A) begin
                m_done = 1'b1;
            end else if (xlate(code, sh, a) && m_len < DEPTH) begin
                mem_m[m_len]     = a;
                mem_known[m_len] = 1'b1;
                m_len++;
                exp_cv = 1'b1;
                m_last = a;
            end
        end

        @(posedge clk);
        #1;
        if (char_valid === 1'b1) cv_seen++;
        check("length",     32'(length),     32'(m_len));
        check("line_done",  32'(line_done),  32'(m_done));
        check("char_valid", 32'(char_valid), 32'(exp_cv));
        check("last_ascii", 32'(last_ascii), 32'(m_last));
        check("full",       32'(full),       32'(m_len == DEPTH));
        if (rd_known) check("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic key(input logic [7:0] code, input bit sh);
        cyc(1'b0, 1'b1, code, sh, 1'b0, 0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic read_expect(input string tag, input int addr, input logic [7:0] val);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, addr);
        check(tag, 32'(rd_data), 32'(val));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cnt     = '0;
        cv_seen = 0;
        m_len   = 0;
        m_done  = 1'b0;
        m_last  = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]     = 8'h00;
            mem_known[i] = 1'b0;
        end

        // Reset values.
        do_reset();
        check("rst_length", 32'(length), 32'd0);
        check("rst_rd",     32'(rd_data), 32'd0);
        check("rst_last",   32'(last_ascii), 32'd0);

        // "abc" lowercase.
        cv_seen = 0;
        key(8'h1C, 1'b0);
        key(8'h32, 1'b0);
        key(8'h21, 1'b0);
        cyc(1'b0, 1'b0, 8'h21, 1'b0, 1'b0, 0);
        check("abc_len",    32'(length), 32'd3);
        check("abc_pulses", 32'(cv_seen), 32'd3);
        check("abc_last",   32'(last_ascii), 32'h63);
        read_expect("abc_m0", 0, 8'h61);
        read_expect("abc_m1", 1, 8'h62);
        read_expect("abc_m2", 2, 8'h63);

        // Shifted letter, shifted digit, space.
        do_reset();
        key(8'h1A, 1'b1);
        key(8'h16, 1'b1);
        key(8'h29, 1'b0);
        read_expect("shf_m0", 0, 8'h5A);
        read_expect("shf_m1", 1, 8'h21);
        read_expect("shf_m2", 2, 8'h20);

        // Backspace down to empty, no underflow.
        do_reset();
        key(8'h1C, 1'b0);
        key(8'h32, 1'b0);
        check("bs_len2", 32'(length), 32'd2);
        key(8'h66, 1'b0);
        check("bs_len1", 32'(length), 32'd1);
        key(8'h66, 1'b0);
        check("bs_len0", 32'(length), 32'd0);
        key(8'h66, 1'b0);
        check("bs_under", 32'(length), 32'd0);
        key(8'h21, 1'b0);
        check("bs_len_c", 32'(length), 32'd1);
        read_expect("bs_m0", 0, 8'h63);

        // Fill to capacity with 'b', then one extra 'a' must be dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) key(8'h32, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        cv_seen = 0;
        key(8'h1C, 1'b0);
        check("fill_nopulse", 32'(cv_seen), 32'd0);
        check("fill_len", 32'(length), 32'd32);
        read_expect("fill_m31", 31, 8'h62);
        read_expect("fill_m0", 0, 8'h62);

        // Commit "hi", locked key discarded, ack unlocks and clears length.
        do_reset();
        key(8'h33, 1'b0);
        key(8'h43, 1'b0);
        key(8'h5A, 1'b0);
        key(8'h1C, 1'b0);
        check("ent_done", 32'(line_done), 32'd1);
        check("ent_len",  32'(length), 32'd2);
        cyc(1'b0, 1'b0, 8'h1C, 1'b0, 1'b1, 0);
        check("ack_done", 32'(line_done), 32'd0);
        check("ack_len",  32'(length), 32'd0);
        key(8'h24, 1'b0);
        read_expect("ack_m0", 0, 8'h65);
        read_expect("ack_m1", 1, 8'h69);
        // Key and ack in the same cycle while locked: ack wins, key dropped.
        key(8'h5A, 1'b0);
        cyc(1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 0);
        check("ackkey_len",  32'(length), 32'd0);
        check("ackkey_done", 32'(line_done), 32'd0);

        // Same code repeated with counter stepping, then counter held.
        do_reset();
        for (int i = 0; i < 4; i++) key(8'h44, 1'b0);
        check("rep_len", 32'(length), 32'd4);
        cyc(1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 8'h21, 1'b0, 1'b0, 0);
        check("hold_len", 32'(length), 32'd4);
        // Reset mid-line.
        key(8'h5A, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("midrst_len",  32'(length), 32'd0);
        check("midrst_done", 32'(line_done), 32'd0);
        check("midrst_cv",   32'(char_valid), 32'd0);
        check("midrst_full", 32'(full), 32'd0);

        // Randomized traffic.
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [7:0]  code;
            bit          evt;
            bit          ack;
            bit          rst;
            r = int'($urandom_range(0, 99));
            if (r < 55)      code = LETTER_CODES[$urandom_range(0, 25)];
            else if (r < 70) code = DIGIT_CODES[$urandom_range(0, 9)];
            else if (r < 75) code = 8'h29;
            else if (r < 85) code = 8'h66;
            else if (r < 88) code = 8'h5A;
            else             code = 8'($urandom_range(0, 255));
            evt = ($urandom_range(0, 99) < 80);
            ack = ($urandom_range(0, 99) < 12);
            rst = ($urandom_range(0, 299) == 0);
            cyc(rst, evt, code, 1'($urandom_range(0, 1)), ack,
                int'($urandom_range(0, DEPTH - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
